regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between NREQ independent writers: core writeback, load-return and debug/IO loader.
- Round-robin arbitration over valid/ready handshakes.
- Registers the winning write and drives the register file's addr_write / data_write / FLAG_register inputs one cycle later.
- Drops writes to R0 so R0 stays architecturally zero.

Parameters:
- NREQ, 3, number of requesters (2..8); index 0 = core writeback.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- hold  input  1  freeze: no grants while high (pipeline stall / debug halt).
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW].
- req_data  input  NREQ*DW  packed data; requester i at bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant (combinational); the write is accepted when valid&ready.
- wr_en  output  1  to FLAG_register.
- wr_addr  output  AW  to addr_write.
- wr_data  output  DW  to data_write.
- grant_id  output  3  index of the requester whose write is on wr_*.
- zero_drop  output  1  one-cycle pulse: accepted write targeted R0 and was discarded.

Behaviour:
- Reset is synchronous. While rst_n is low at a posedge, the following registers load 0: wr_en, wr_addr, wr_data, grant_id, zero_drop and rr_ptr. req_ready is forced to 0 combinationally while rst_n is low.
- Arbitration is combinational each cycle:
  - If hold=1, or no req_valid bit is set, req_ready=0.
  - Otherwise req_ready is one-hot on the first valid index found searching upward from rr_ptr, wrapping modulo NREQ.
  - Non-winners see ready=0 and must keep valid asserted to retry.
  - The arbiter places no stability requirement on requesters; it re-evaluates every cycle.
- Acceptance in cycle N drives the outputs on the posedge ending N, visible in cycle N+1:
  - wr_addr and wr_data take the winner's addr and data.
  - grant_id takes the winner's index.
  - wr_en = (addr != 0).
  - zero_drop = (addr == 0).
  - rr_ptr = (winner+1) mod NREQ.
- The register file commits the write at the posedge ending N+1, so total latency from acceptance to architectural write is 2 edges.
- No acceptance: wr_en<=0, zero_drop<=0; wr_addr, wr_data, grant_id and rr_ptr hold their values.
- Throughput: one accepted write per cycle maximum; back-to-back grants allowed, including to the same requester when it is the only valid one.
- Fairness: with hold low, a continuously valid requester is granted within NREQ cycles.
- hold rising while wr_en=1: the already-registered write still completes in that cycle. hold only blocks new grants.
- Reset mid-operation: a registered write not yet committed is discarded (wr_en cleared), and no ready is issued during reset. Requesters re-present after reset.
- Simultaneous requests to the same address from different requesters are serialized in grant order; the last granted wins in the register file.
- Out-of-range rr_ptr (NREQ not a power of 2) cannot occur: the pointer wraps explicitly at NREQ-1 -> 0.
- Widths: the grant_id upper bits are 0 when NREQ<8. No arithmetic is performed on the data.

Test Plan:
- Reset then single request: rst_n=0 for 2 cycles, then req_valid=3'b001, addr=5, data=0xDEADBEEF. Required: ready[0]=1 in the same cycle; the next cycle has wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=0; the register read after the following edge returns 0xDEADBEEF.
- Round-robin: all three requesters valid continuously for 6 cycles, starting from rr_ptr=0. Required: grant order 0,1,2,0,1,2 and wr_en high every cycle from the second.
- R0 drop: requester 2 writes addr=0, data=0x1234. Required: ready[2]=1; next cycle wr_en=0, zero_drop=1, grant_id=2; R0 still reads 0; rr_ptr advances to 0.
- Hold: all requesters valid, hold=1 for 3 cycles. Required: req_ready=0 and wr_en=0 after the first held cycle. On release, the grant goes to the index rr_ptr held before hold.
- Reset mid-write: accept addr=7, data=0xA5A5A5A5, then assert rst_n=0 on the following cycle. Required: wr_en=0 after that edge and R7 unchanged.
- Same-address collision: requesters 0 and 1 both write addr=9 (0x11, 0x22) with rr_ptr=0. Required: 0x11 then 0x22 committed on consecutive cycles; R9 ends at 0x22.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ writers.
// The winning write is registered and presented on wr_* one cycle after acceptance; R0 writes are dropped.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic [2:0]         grant_id,
    output logic               zero_drop
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic            zero_drop_q, zero_drop_d;

    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic [NREQ-1:0] grant_oh;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            accept;

    // Search upward from rr_ptr, wrapping explicitly so the index never leaves 0..NREQ-1.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        grant_oh  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && req_valid[idx]) begin
                win_found     = 1'b1;
                win_idx       = PW'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

    assign req_ready = (rst_n && !hold) ? grant_oh : '0;
    assign accept    = |req_ready;
    assign win_addr  = req_addr[int'(win_idx)*AW +: AW];
    assign win_data  = req_data[int'(win_idx)*DW +: DW];

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant_id_d  = grant_id_q;
        zero_drop_d = 1'b0;
        if (accept) begin
            wr_addr_d   = win_addr;
            wr_data_d   = win_data;
            grant_id_d  = 3'(win_idx);
            wr_en_d     = (win_addr != '0);
            zero_drop_d = (win_addr == '0);
            rr_ptr_d    = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            grant_id_q  <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            grant_id_q  <= grant_id_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    // Masking with rst_n keeps a registered but uncommitted write out of the register file
    // during the very cycle reset is asserted.
    assign wr_en     = wr_en_q & rst_n;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign grant_id  = grant_id_q;
    assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued at issue time and
// compared by a monitor whenever the DUT presents a write or an R0 drop.
module tb_regfile_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int EW   = 2 + 3 + AW + DW;

    logic               clk;
    logic               rst_n;
    logic               hold;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [2:0]         grant_id;
    logic               zero_drop;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] rf[32];
    logic          rf_clr;
    int            checks;
    int            errors;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .zero_drop (zero_drop)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file model fed by the write port
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wr_en === 1'b1) begin
            rf[wr_addr] <= wr_data;
        end
    end

    function automatic logic [EW-1:0] mk(input logic zd, input logic en, input logic [2:0] gid,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {zd, en, gid, a, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic rn, input logic h, input logic [2:0] v,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        rst_n     = rn;
        hold      = h;
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rn, input logic h, input logic [2:0] v,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d1, input logic [DW-1:0] d0,
                        input logic [2:0] exp_ready, input logic push, input logic [EW-1:0] item);
        drive(rn, h, v, a2, a1, a0, d2, d1, d0);
        #2;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (push) exp_q.push_back(item);
        tick();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, '0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (wr_en === 1'b1 || zero_drop === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h expected none",
                         {zero_drop, wr_en, grant_id, wr_addr, wr_data});
            end else begin
                chk("write_port", 64'({zero_drop, wr_en, grant_id, wr_addr, wr_data}),
                    64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rf_clr = 1'b1;

        // reset with requesters already valid: no ready may be issued
        step(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 3'b000, 1'b0, '0);
        rf_clr = 1'b0;
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_wr_addr", 64'(wr_addr), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_grant_id", 64'(grant_id), 64'd0);
        chk("reset_zero_drop", 64'(zero_drop), 64'd0);
        step(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 3'b000, 1'b0, '0);

        // single request after reset
        step(1'b1, 1'b0, 3'b001, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'hDEADBEEF, 3'b001, 1'b1,
             mk(1'b0, 1'b1, 3'd0, 5'd5, 32'hDEADBEEF));
        idle();
        chk("rf_r5", 64'(rf[5]), 64'hDEADBEEF);

        // move pointer back to 0 via requester 2
        step(1'b1, 1'b0, 3'b100, 5'd3, 5'd0, 5'd0, 32'h33, 32'h0, 32'h0, 3'b100, 1'b1,
             mk(1'b0, 1'b1, 3'd2, 5'd3, 32'h33));

        // round robin with all three valid
        for (int r = 0; r < 2; r++) begin
            step(1'b1, 1'b0, 3'b111, 5'd12, 5'd11, 5'd10, 32'h300, 32'h200, 32'h100, 3'b001, 1'b1,
                 mk(1'b0, 1'b1, 3'd0, 5'd10, 32'h100));
            step(1'b1, 1'b0, 3'b111, 5'd12, 5'd11, 5'd10, 32'h300, 32'h200, 32'h100, 3'b010, 1'b1,
                 mk(1'b0, 1'b1, 3'd1, 5'd11, 32'h200));
            step(1'b1, 1'b0, 3'b111, 5'd12, 5'd11, 5'd10, 32'h300, 32'h200, 32'h100, 3'b100, 1'b1,
                 mk(1'b0, 1'b1, 3'd2, 5'd12, 32'h300));
        end

        // grant 0 to leave the pointer at 1, then R0 drop from requester 2
        step(1'b1, 1'b0, 3'b001, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h44, 3'b001, 1'b1,
             mk(1'b0, 1'b1, 3'd0, 5'd4, 32'h44));
        step(1'b1, 1'b0, 3'b100, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 3'b100, 1'b1,
             mk(1'b1, 1'b0, 3'd2, 5'd0, 32'h1234));
        // pointer must now be 0: requester 0 wins over 1, then 1 retries
        step(1'b1, 1'b0, 3'b011, 5'd0, 5'd13, 5'd6, 32'h0, 32'hBB, 32'h66, 3'b001, 1'b1,
             mk(1'b0, 1'b1, 3'd0, 5'd6, 32'h66));
        chk("rf_r0_after_drop", 64'(rf[0]), 64'd0);
        step(1'b1, 1'b0, 3'b010, 5'd0, 5'd13, 5'd6, 32'h0, 32'hBB, 32'h66, 3'b010, 1'b1,
             mk(1'b0, 1'b1, 3'd1, 5'd13, 32'hBB));

        // hold for 3 cycles; the write from requester 1 still completes in the first
        for (int h = 0; h < 3; h++) begin
            step(1'b1, 1'b1, 3'b111, 5'd12, 5'd11, 5'd10, 32'h600, 32'h500, 32'h400, 3'b000, 1'b0, '0);
            chk("hold_wr_en", 64'(wr_en), 64'd0);
        end
        step(1'b1, 1'b0, 3'b111, 5'd12, 5'd11, 5'd10, 32'h600, 32'h500, 32'h400, 3'b100, 1'b1,
             mk(1'b0, 1'b1, 3'd2, 5'd12, 32'h600));
        idle();
        chk("rf_r12", 64'(rf[12]), 64'h600);
        chk("rf_r4", 64'(rf[4]), 64'h44);
        chk("rf_r13", 64'(rf[13]), 64'hBB);
        chk("rf_r0", 64'(rf[0]), 64'd0);

        // reset asserted the cycle after acceptance
        step(1'b1, 1'b0, 3'b001, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA5A5A5A5, 3'b001, 1'b0, '0);
        drive(1'b0, 1'b0, 3'b001, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA5A5A5A5);
        #2;
        chk("midreset_ready", 64'(req_ready), 64'd0);
        chk("midreset_wr_en_live", 64'(wr_en), 64'd0);
        tick();
        chk("midreset_wr_en", 64'(wr_en), 64'd0);
        chk("midreset_wr_addr", 64'(wr_addr), 64'd0);
        chk("rf_r7", 64'(rf[7]), 64'd0);

        // same-address collision after reset (pointer back at 0)
        step(1'b1, 1'b0, 3'b011, 5'd0, 5'd9, 5'd9, 32'h0, 32'h22, 32'h11, 3'b001, 1'b1,
             mk(1'b0, 1'b1, 3'd0, 5'd9, 32'h11));
        step(1'b1, 1'b0, 3'b010, 5'd0, 5'd9, 5'd9, 32'h0, 32'h22, 32'h11, 3'b010, 1'b1,
             mk(1'b0, 1'b1, 3'd1, 5'd9, 32'h22));
        chk("rf_r9_first", 64'(rf[9]), 64'h11);
        idle();
        idle();
        chk("rf_r9_final", 64'(rf[9]), 64'h22);
        chk("rf_r7_final", 64'(rf[7]), 64'd0);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
